spi_slave_tx: RTL

SPI mode-0 slave transmitter that returns bytes to the RP2040 on MISO. It is the transmit counterpart of `spi_slave`, which receives on MOSI, and shares the same `spi_sck`/`spi_cs` pins in `system_top`. Internal logic loads bytes through a one-entry holding register with a valid/ready handshake. The block serialises each byte MSB-first on MISO, synchronously to the 25 MHz system clock.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sync_edge.sv | 30 +++
 rtl/spi_slave_tx.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared constants and state type for the SPI slave datapath blocks.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W    = 8;
  localparam int unsigned SPI_BIT_CNT_W = $clog2(SPI_BYTE_W);

  localparam logic [SPI_BYTE_W-1:0] SPI_DEFAULT_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_tx_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin plus a one-cycle rise/fall
// strobe generator; RST_VAL should match the pin's idle level.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_c = sync_q[STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave transmitter: one-entry holding register feeding an
// MSB-first shifter on MISO, all logic in the system clock domain.
module spi_slave_tx
  import spi_pkg::*;
#(
  parameter logic [SPI_BYTE_W-1:0] DEFAULT_BYTE = SPI_DEFAULT_BYTE,
  parameter int unsigned           SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_sck,
  input  logic                  spi_cs,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_done,
  output logic                  tx_underrun,
  output logic                  tx_abort,
  output logic                  busy
);

  localparam logic [SPI_BIT_CNT_W-1:0] LAST_BIT = SPI_BIT_CNT_W'(SPI_BYTE_W - 1);

  logic sck_rise;
  logic sck_fall;
  logic cs_rise;
  logic cs_fall;

  spi_tx_state_t              state;
  logic [SPI_BIT_CNT_W-1:0]   bit_cnt;
  logic                       reload;
  logic [SPI_BYTE_W-1:0]      hold_q;
  logic [SPI_BYTE_W-1:0]      shift_q;
  logic                       load_c;

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sck_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (spi_sck),
    .rise_c (sck_rise),
    .fall_c (sck_fall)
  );

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_cs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (spi_cs),
    .rise_c (cs_rise),
    .fall_c (cs_fall)
  );

  // Shifter load point: start of selection, or first SCK fall after a full byte.
  assign load_c = !cs_rise &&
                  ((state == IDLE && cs_fall) || (state == SHIFT && sck_fall && reload));

  assign spi_miso = shift_q[SPI_BYTE_W-1];

  // Holding register; a load sees the pre-write state, so a same-cycle write stays queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= '0;
      tx_ready <= 1'b1;
    end else if (load_c && !tx_ready) begin
      tx_ready <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      hold_q   <= tx_data;
      tx_ready <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      reload      <= 1'b0;
      shift_q     <= '0;
      tx_done     <= 1'b0;
      tx_underrun <= 1'b0;
      tx_abort    <= 1'b0;
      busy        <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      tx_done     <= 1'b0;
      tx_underrun <= 1'b0;
      tx_abort    <= 1'b0;

      if (load_c) begin
        shift_q     <= tx_ready ? DEFAULT_BYTE : hold_q;
        tx_underrun <= tx_ready;
      end

      // Deselect has priority over any SCK activity in the same cycle.
      if (cs_rise) begin
        state       <= IDLE;
        busy        <= 1'b0;
        spi_miso_oe <= 1'b0;
        shift_q     <= '0;
        bit_cnt     <= '0;
        reload      <= 1'b0;
        tx_abort    <= (bit_cnt != '0);
      end else begin
        unique case (state)
          IDLE: begin
            if (cs_fall) begin
              state       <= LOAD;
              busy        <= 1'b1;
              spi_miso_oe <= 1'b1;
            end
          end
          LOAD: begin
            state <= SHIFT;
          end
          SHIFT: begin
            if (sck_rise) begin
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                reload  <= 1'b1;
                tx_done <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (sck_fall) begin
              if (reload) begin
                reload <= 1'b0;
              end else begin
                shift_q <= {shift_q[SPI_BYTE_W-2:0], 1'b0};
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
